mux_shift_chain: RTL

MUX_SHIFT_CHAIN -- requirements
Module: mux_shift_chain

---
 rtl/mux_shift_pkg.sv | 23 ++
 rtl/mux_dff_stage.sv | 41 ++++
 rtl/mux_shift_chain.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mux_shift_pkg.sv
// Shared types for the mux_shift_chain block.
//   state_e : burst controller states (IDLE, BURST)
//   sel_e   : per-stage input select used by mux_dff_stage
//   DIR_*   : encoding of the dir input
package mux_shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // FROM_HI takes bit i+1 (shift right), FROM_LO takes bit i-1 (shift left).
  typedef enum logic [1:0] {
    SEL_HOLD    = 2'd0,
    SEL_LOAD    = 2'd1,
    SEL_FROM_HI = 2'd2,
    SEL_FROM_LO = 2'd3
  } sel_e;

endpackage

// File: rtl/mux_dff_stage.sv
// One bit of the shift chain: a 4-way select feeding a synchronous-reset flop.
//   clk, reset : clock and synchronous active-high reset
//   sel        : hold / load / from higher neighbour / from lower neighbour
//   load_bit   : parallel load value for this bit
//   from_hi    : value of bit i+1 (or the fill bit at the top end)
//   from_lo    : value of bit i-1 (or the fill bit at the bottom end)
//   q          : stored bit
module mux_dff_stage
  import mux_shift_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  sel_e sel,
  input  logic load_bit,
  input  logic from_hi,
  input  logic from_lo,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    case (sel)
      SEL_HOLD:    q_d = q_q;
      SEL_LOAD:    q_d = load_bit;
      SEL_FROM_HI: q_d = from_hi;
      SEL_FROM_LO: q_d = from_lo;
      default:     q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mux_shift_chain.sv
// Loadable shift/rotate register with a counted burst-shift controller.
//   clk, reset   : clock and synchronous active-high reset
//   L, r_in      : parallel load strobe and data (highest priority)
//   ser_in       : fill bit when not rotating
//   shift_en     : single-step shift request (idle only)
//   dir, rotate  : 0 = right / 1 = left; 1 = rotate, 0 = fill from ser_in
//   start        : burst request, burst_len shifts follow the capture edge
//   Q            : register contents
//   ser_out      : exiting bit for the active direction
//   busy, done   : burst in progress; one-cycle completion pulse
// Handshake: start is a single-cycle request accepted only when busy=0 and
// L=0; done pulses once for each accepted start unless L or reset aborts it.
module mux_shift_chain
  import mux_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             L,
  input  logic [WIDTH-1:0] r_in,
  input  logic             ser_in,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             rotate,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] Q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               dir_d, dir_q;
  logic               rot_d, rot_q;
  logic               done_d, done_q;

  sel_e               sel;
  logic               shift_dir;
  logic               shift_rot;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   from_hi;
  logic [WIDTH-1:0]   from_lo;
  logic               fill_hi;
  logic               fill_lo;

  // One action per edge: load > burst shift > start > single shift > hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    rot_d     = rot_q;
    done_d    = 1'b0;
    sel       = SEL_HOLD;
    shift_dir = dir;
    shift_rot = rotate;
    if (L) begin
      sel     = SEL_LOAD;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == BURST) begin
      shift_dir = dir_q;
      shift_rot = rot_q;
      sel       = (dir_q == DIR_LEFT) ? SEL_FROM_LO : SEL_FROM_HI;
      cnt_d     = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      dir_d = dir;
      rot_d = rotate;
      cnt_d = burst_len;
      // A zero-length burst completes on the capture edge itself.
      if (burst_len == '0) done_d  = 1'b1;
      else                 state_d = BURST;
    end else if (shift_en) begin
      sel = (dir == DIR_LEFT) ? SEL_FROM_LO : SEL_FROM_HI;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      rot_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
    end
  end

  // End-stage fill: the vacated bit takes the exiting bit or ser_in.
  assign fill_hi = shift_rot ? q[0]       : ser_in;
  assign fill_lo = shift_rot ? q[WIDTH-1] : ser_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == WIDTH - 1) begin : g_hi_end
      assign from_hi[i] = fill_hi;
    end else begin : g_hi_mid
      assign from_hi[i] = q[i+1];
    end
    if (i == 0) begin : g_lo_end
      assign from_lo[i] = fill_lo;
    end else begin : g_lo_mid
      assign from_lo[i] = q[i-1];
    end

    mux_dff_stage u_stage (
      .clk      (clk),
      .reset    (reset),
      .sel      (sel),
      .load_bit (r_in[i]),
      .from_hi  (from_hi[i]),
      .from_lo  (from_lo[i]),
      .q        (q[i])
    );
  end

  assign Q       = q;
  assign busy    = (state_q == BURST);
  assign done    = done_q;
  // During a burst the exiting bit follows the latched direction.
  assign ser_out = ((busy ? dir_q : dir) == DIR_LEFT) ? q[WIDTH-1] : q[0];

endmodule
